// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised datapath register file.
// Holds the sequencer state encoding and the depth helper.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_AWIDTH = 3;

    function automatic int regfile_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then raises Ready.
// Latency: DEPTH cycles after Reset deasserts; no backpressure, always advances.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              clr_we_o,
    output logic [AWIDTH-1:0] clr_addr_o,
    output logic [DWIDTH-1:0] clr_data_o,
    output logic              run_o,
    output logic              ready_o
);

    localparam int DEPTH = regfile_depth(AWIDTH);
    localparam int PTR_W = AWIDTH + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic             ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + PTR_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // The reset cycle itself must leave the array untouched.
    assign clr_we_o   = (state_q == CLEAR) && !rst_i;
    assign clr_addr_o = ptr_q[AWIDTH-1:0];
    assign clr_data_o = CLR_VALUE;
    assign run_o      = (state_q == RUN);
    assign ready_o    = ready_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file, registered reads (latency 1) with ReadValid.
// Optional write-first bypass via REGFILE_WRITE_BYPASS_EN; reads/writes ignored until Ready.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int ZERO_REG = 1,
    parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReadEn,
    input  logic [AWIDTH-1:0] ReadRegister1,
    input  logic [AWIDTH-1:0] ReadRegister2,
    input  logic              RegWrite,
    input  logic [AWIDTH-1:0] WriteRegister,
    input  logic [DWIDTH-1:0] WriteData,
    output logic [DWIDTH-1:0] ReadData1,
    output logic [DWIDTH-1:0] ReadData2,
    output logic              ReadValid,
    output logic              Ready
);

    localparam int DEPTH = regfile_depth(AWIDTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd1_q, rd2_q, rd1_d, rd2_d;
    logic              rvld_q;

    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;
    logic [DWIDTH-1:0] clr_data;
    logic              run;

    regfile_clear_seq #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .CLR_VALUE (CLR_VALUE)
    ) u_clear_seq (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .clr_data_o (clr_data),
        .run_o      (run),
        .ready_o    (Ready)
    );

    logic wr_zero, rd1_zero, rd2_zero, usr_we;

    assign wr_zero  = (ZERO_REG != 0) && (WriteRegister == '0);
    assign rd1_zero = (ZERO_REG != 0) && (ReadRegister1 == '0);
    assign rd2_zero = (ZERO_REG != 0) && (ReadRegister2 == '0);
    assign usr_we   = run && RegWrite && !wr_zero;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (clr_we) begin
                mem_q[clr_addr] <= clr_data;
            end else if (usr_we) begin
                mem_q[WriteRegister] <= WriteData;
            end
        end
    end

    always_comb begin
        rd1_d = mem_q[ReadRegister1];
        rd2_d = mem_q[ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (RegWrite && (WriteRegister == ReadRegister1)) rd1_d = WriteData;
        if (RegWrite && (WriteRegister == ReadRegister2)) rd2_d = WriteData;
`endif
        // Hardwired zero wins over both the array and the bypass.
        if (rd1_zero) rd1_d = '0;
        if (rd2_zero) rd2_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            rvld_q <= 1'b0;
        end else if (run && ReadEn) begin
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            rvld_q <= 1'b1;
        end else begin
            rvld_q <= 1'b0;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign ReadValid = rvld_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench: default build, a ZERO_REG=0 twin sharing its inputs, and a 32x32 build.
module tb_regfile_param;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReadEn, RegWrite;
    logic [2:0]  RR1, RR2, WR;
    logic [15:0] WD;
    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_vld, a_rdy, b_vld, b_rdy;

    logic        c_ReadEn, c_RegWrite;
    logic [4:0]  c_RR1, c_RR2, c_WR;
    logic [31:0] c_WD, c_rd1, c_rd2;
    logic        c_vld, c_rdy;

    int checks = 0;
    int failures = 0;
    int ra, rb, rc;

    always #5 Clk = ~Clk;

    regfile_param #(.DWIDTH(16), .AWIDTH(3), .ZERO_REG(1)) u_a (
        .Clk(Clk), .Reset(Reset), .ReadEn(ReadEn), .ReadRegister1(RR1), .ReadRegister2(RR2),
        .RegWrite(RegWrite), .WriteRegister(WR), .WriteData(WD),
        .ReadData1(a_rd1), .ReadData2(a_rd2), .ReadValid(a_vld), .Ready(a_rdy));

    regfile_param #(.DWIDTH(16), .AWIDTH(3), .ZERO_REG(0)) u_b (
        .Clk(Clk), .Reset(Reset), .ReadEn(ReadEn), .ReadRegister1(RR1), .ReadRegister2(RR2),
        .RegWrite(RegWrite), .WriteRegister(WR), .WriteData(WD),
        .ReadData1(b_rd1), .ReadData2(b_rd2), .ReadValid(b_vld), .Ready(b_rdy));

    regfile_param #(.DWIDTH(32), .AWIDTH(5), .ZERO_REG(1)) u_c (
        .Clk(Clk), .Reset(Reset), .ReadEn(c_ReadEn), .ReadRegister1(c_RR1), .ReadRegister2(c_RR2),
        .RegWrite(c_RegWrite), .WriteRegister(c_WR), .WriteData(c_WD),
        .ReadData1(c_rd1), .ReadData2(c_rd2), .ReadValid(c_vld), .Ready(c_rdy));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; ReadEn = 1'b0; RegWrite = 1'b0;
        RR1 = '0; RR2 = '0; WR = '0; WD = '0;
        c_ReadEn = 1'b0; c_RegWrite = 1'b0; c_RR1 = '0; c_RR2 = '0; c_WR = '0; c_WD = '0;
        tick(); tick();
        chk("reset_rd1", 64'(a_rd1), 64'h0);
        chk("reset_rd2", 64'(a_rd2), 64'h0);
        chk("reset_vld", 64'(a_vld), 64'h0);
        chk("reset_rdy", 64'(a_rdy), 64'h0);

        // Ready must rise exactly DEPTH edges after Reset drops.
        Reset = 1'b0;
        ra = 0; rb = 0; rc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (a_rdy && ra == 0) ra = i;
            if (b_rdy && rb == 0) rb = i;
            if (c_rdy && rc == 0) rc = i;
        end
        chk("clear_len_a", 64'(ra), 64'd8);
        chk("clear_len_b", 64'(rb), 64'd8);
        chk("clear_len_c", 64'(rc), 64'd32);

        for (int a = 0; a < 8; a++) begin
            ReadEn = 1'b1; RR1 = 3'(a); RR2 = 3'(7 - a);
            tick();
            chk("cleared_rd1", 64'(a_rd1), 64'h0);
            chk("cleared_rd2", 64'(a_rd2), 64'h0);
            chk("cleared_vld", 64'(a_vld), 64'h1);
        end

        ReadEn = 1'b0; RegWrite = 1'b1; WR = 3'd3; WD = 16'h0007;
        tick();
        RegWrite = 1'b0; ReadEn = 1'b1; RR1 = 3'd3; RR2 = 3'd3;
        tick();
        chk("r3_rd1", 64'(a_rd1), 64'h0007);
        chk("r3_rd2", 64'(a_rd2), 64'h0007);
        chk("r3_vld", 64'(a_vld), 64'h1);
        ReadEn = 1'b0;
        tick();
        chk("idle_vld", 64'(a_vld), 64'h0);
        chk("idle_hold", 64'(a_rd1), 64'h0007);

        RegWrite = 1'b1; WR = 3'd0; WD = 16'hFFFF;
        tick();
        RegWrite = 1'b0; ReadEn = 1'b1; RR1 = 3'd0; RR2 = 3'd3;
        tick();
        chk("zero_reg_a", 64'(a_rd1), 64'h0000);
        chk("zero_reg_b", 64'(b_rd1), 64'hFFFF);
        chk("zero_reg_r3", 64'(a_rd2), 64'h0007);

        ReadEn = 1'b0; RegWrite = 1'b1; WR = 3'd5; WD = 16'h0006;
        tick();
        WD = 16'h1234; ReadEn = 1'b1; RR1 = 3'd5; RR2 = 3'd3;
        tick();
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("same_cycle_r5", 64'(a_rd1), 64'h1234);
`else
        chk("same_cycle_r5", 64'(a_rd1), 64'h0006);
`endif
        chk("same_cycle_other", 64'(a_rd2), 64'h0007);
        RegWrite = 1'b0;
        tick();
        chk("r5_after", 64'(a_rd1), 64'h1234);

        RegWrite = 1'b1; WR = 3'd0; WD = 16'hABCD; RR1 = 3'd0; RR2 = 3'd5;
        tick();
        chk("zero_bypass_a", 64'(a_rd1), 64'h0000);
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("zero_bypass_b", 64'(b_rd1), 64'hABCD);
`else
        chk("zero_bypass_b", 64'(b_rd1), 64'hFFFF);
`endif
        RegWrite = 1'b0; ReadEn = 1'b0;

        c_RegWrite = 1'b1; c_WR = 5'd31; c_WD = 32'hDEADBEEF;
        tick();
        c_RegWrite = 1'b0; c_ReadEn = 1'b1; c_RR1 = 5'd31; c_RR2 = 5'd30;
        tick();
        chk("c_r31", 64'(c_rd1), 64'hDEADBEEF);
        chk("c_r30", 64'(c_rd2), 64'h0);
        chk("c_vld", 64'(c_vld), 64'h1);
        c_ReadEn = 1'b0;

        // Reset at clear cycle 4, with writes and reads pressed throughout the clear.
        Reset = 1'b1;
        tick();
        Reset = 1'b0; RegWrite = 1'b1; WR = 3'd2; WD = 16'hBEEF;
        ReadEn = 1'b1; RR1 = 3'd3; RR2 = 3'd5;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("clr1_vld", 64'(a_vld), 64'h0);
            chk("clr1_hold", 64'(a_rd1), 64'h0);
            chk("clr1_rdy", 64'(a_rdy), 64'h0);
        end
        Reset = 1'b1;
        tick();
        chk("rst2_rdy", 64'(a_rdy), 64'h0);
        chk("rst2_vld", 64'(a_vld), 64'h0);
        Reset = 1'b0;
        ra = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a_rdy && ra == 0) begin
                ra = i;
                RegWrite = 1'b0; ReadEn = 1'b0;
            end
            if (ra == 0) chk("clr2_vld", 64'(a_vld), 64'h0);
        end
        chk("clear2_len", 64'(ra), 64'd8);

        ReadEn = 1'b1; RR1 = 3'd2; RR2 = 3'd5;
        tick();
        chk("clr_no_write", 64'(a_rd1), 64'h0);
        chk("clr_r5_cleared", 64'(a_rd2), 64'h0);
        chk("clr_final_vld", 64'(a_vld), 64'h1);
        ReadEn = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor of the 8x16 datapath register file for the multi-cycle core.
- Generalised in data width and depth, with a configurable hardwired-zero register.
- Adds a single-clock, posedge-only registered read path with valid flag, a write-ignore rule for register 0, and a post-reset clear sequencer that walks every entry.
- Sits between the decode stage (read addresses) and the write-back mux (write port).

Parameters:
- DWIDTH, 16, data width in bits.
- AWIDTH, 3, address width; DEPTH = 2**AWIDTH entries.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.
- CLR_VALUE, 0, DWIDTH-bit value written to every entry by the clear sequencer.

Ports:
- Clk  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReadEn  in  1  read request; samples both read addresses.
- ReadRegister1  in  AWIDTH  read port 1 address.
- ReadRegister2  in  AWIDTH  read port 2 address.
- RegWrite  in  1  write strobe.
- WriteRegister  in  AWIDTH  write address.
- WriteData  in  DWIDTH  write data.
- ReadData1  out  DWIDTH  registered read data, port 1.
- ReadData2  out  DWIDTH  registered read data, port 2.
- ReadValid  out  1  ReadData1/2 hold a fresh result this cycle.
- Ready  out  1  clear sequence done; array accepts reads and writes.

Behaviour:
- Reset (sampled at posedge):
  - ReadData1 = ReadData2 = 0; ReadValid = 0; Ready = 0.
  - State = CLEAR; ClrPtr = 0.
  - Array contents are not touched in the reset cycle itself.
- State CLEAR:
  - Each cycle writes CLR_VALUE to entry ClrPtr, then ClrPtr increments.
  - When ClrPtr = DEPTH-1 is written, the next state is RUN and Ready = 1 from the following cycle.
  - Clear takes exactly DEPTH cycles after Reset deasserts.
  - RegWrite is ignored and ReadEn is ignored: ReadValid stays 0 and ReadData holds.
- State RUN:
  - Write: RegWrite=1 writes WriteData to entry WriteRegister at the posedge.
  - Zero register: when ZERO_REG=1, a write to address 0 is dropped and entry 0 stays 0.
  - Read: ReadEn=1 at edge N gives ReadData1/2 = contents at addresses sampled at edge N, with ReadValid=1 during cycle N+1 (latency 1).
  - ReadEn=0 gives ReadValid=0 next cycle and ReadData holds its last value.
  - Simultaneous read and write to the same address in one cycle returns the OLD value, unless the optional bypass below is enabled.
  - ZERO_REG=1 with read address 0 always returns 0, regardless of bypass.
- Reset asserted mid-CLEAR or mid-RUN: immediately restarts CLEAR from ClrPtr=0; any pending ReadValid is cleared.
- ClrPtr is AWIDTH+1 bits wide internally so the terminal compare does not wrap.
- No X propagation: all outputs are defined from the first post-reset cycle.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in RUN, if RegWrite=1, ReadEn=1 and WriteRegister equals a read address (and that address is non-zero when ZERO_REG=1), that port returns WriteData. This gives write-first semantics.
- Undefined: read-first semantics, returning the old value.
- Bypass is never active in CLEAR.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, RUN};
  - default DWIDTH/AWIDTH constants;
  - a function computing DEPTH from AWIDTH.
- One natural sub-module, regfile_clear_seq:
  - holds ClrPtr, the state register and Ready;
  - outputs the clear write-enable/address/data, which are muxed onto the array write port by regfile_param.

Test Plan:
- Reset then idle, DWIDTH=16, AWIDTH=3 -> Ready rises exactly 8 cycles after Reset deasserts; reading all 8 entries returns 16'h0000.
- RUN: write R3=16'h0007, then ReadEn with addresses 3/3 -> next cycle ReadData1=ReadData2=16'h0007, ReadValid=1.
- ZERO_REG=1: write R0=16'hFFFF, then read R0 -> 16'h0000; same write with ZERO_REG=0 -> 16'hFFFF.
- Same-cycle write R5=16'h1234 over old 16'h0006 while reading R5 -> 16'h0006 without the macro, 16'h1234 with REGFILE_WRITE_BYPASS_EN; read of R5 next cycle returns 16'h1234 in both builds.
- Reset asserted at clear cycle 4 -> Ready stays 0 and the clear restarts at entry 0, finishing 8 cycles after the second Reset; RegWrite/ReadEn issued during clear produce no write and ReadValid=0.
- AWIDTH=5, DWIDTH=32 build -> clear takes 32 cycles; write/read of entry 31 = 32'hDEADBEEF round-trips.
